fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS datapath. It replaces the single-register fetch latch with a PC generator plus an N-entry fetch queue, so decode can stall without losing fetched words. It also adds redirect-with-flush for branch/jump targets, fetch gating and misaligned-target detection. It sits between the instruction memory and the control/decode stage; decode consumes instructions through a valid/ready handshake.

---
 rtl/fetch_queue_unit.sv | 107 ++++++++++
 tb/tb_fetch_queue_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generator with N-entry fetch queue, redirect flush and misalign flag
module fetch_queue_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_BYTES = 128,
  parameter int              FQ_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  localparam int             AW         = $clog2(IMEM_BYTES),
  localparam int             CW         = $clog2(FQ_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [AW-1:0]   imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic [CW-1:0]   fq_count_o,
  output logic            misalign_err_o
);

  localparam int PW = CW - 1;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_mem_q    [FQ_DEPTH];
  logic [XLEN-1:0] instr_mem_q [FQ_DEPTH];

  logic full;
  logic pop;
  logic push;

  // Handshake enables; a redirect suppresses both push and pop in its cycle
  always_comb begin
    full = (count_q == CW'(FQ_DEPTH));
    pop  = instr_valid_o & instr_ready_i & ~redirect_valid_i;
    push = fetch_en_i & ~redirect_valid_i & (~full | pop);
  end

  // Next-state for PC, pointers, occupancy and the sticky misalign flag
  always_comb begin
    fpc_d      = fpc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    if (redirect_valid_i) begin
      fpc_d      = {redirect_pc_i[XLEN-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      misalign_d = misalign_q | (redirect_pc_i[1:0] != 2'b00);
    end else begin
      if (push) begin
        fpc_d    = fpc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state register, falling-edge to match the datapath
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpc_q      <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Queue storage is not reset; the head is gated by occupancy instead
  always_ff @(negedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fpc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  // Outputs depend only on registered state
  always_comb begin
    imem_addr_o    = fpc_q[AW-1:0];
    instr_valid_o  = (count_q != '0);
    instr_o        = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
    instr_pc_o     = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
    fq_count_o     = count_q;
    misalign_err_o = misalign_q;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed self-checking bench for fetch_queue_unit
module tb_fetch_queue_unit;

  localparam int XLEN = 32;
  localparam int AW   = 7;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [CW-1:0]   fq_count;
  logic            misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue_unit #(
    .XLEN(32), .IMEM_BYTES(128), .FQ_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .fq_count_o(fq_count),
    .misalign_err_o(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory byte at address x (x taken modulo 128)
  function automatic logic [7:0] mem_byte(input int x);
    return 8'(((x % 128) * 7) + 3);
  endfunction

  function automatic logic [31:0] word_at(input int pc);
    return {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
  endfunction

  always_comb imem_rdata = word_at(int'(imem_addr));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past one falling edge; sample point sits 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    step(); step();
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_count", 32'(fq_count), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_pc", instr_pc, 32'd0);
    check_eq("rst_mis", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("idle_count", 32'(fq_count), 32'd0);

    // Streaming: one instruction per cycle, occupancy stays 1
    fetch_en = 1'b1; instr_ready = 1'b1;
    step();
    check_eq("first_word", instr, 32'h18110A03);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      check_eq("stream_pc", instr_pc, 32'(4 * k));
      check_eq("stream_instr", instr, word_at(4 * k));
      check_eq("stream_count", 32'(fq_count), 32'd1);
    end

    // Flush back to 0, then backpressure until full
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    check_eq("flush_count", 32'(fq_count), 32'd0);
    check_eq("flush_valid", 32'(instr_valid), 32'd0);
    redirect_valid = 1'b0; instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("bp_count", 32'(fq_count), 32'((k + 1 > 4) ? 4 : k + 1));
    end
    check_eq("bp_addr", 32'(imem_addr), 32'd16);
    check_eq("bp_head", instr_pc, 32'd0);
    instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("drain_pc", instr_pc, 32'(4 * k));
      check_eq("drain_count", 32'(fq_count), 32'd4);
    end

    // Hold 3 entries, then redirect with ready high
    fetch_en = 1'b0;
    step();
    check_eq("three_count", 32'(fq_count), 32'd3);
    check_eq("three_head", instr_pc, 32'd20);
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h14;
    step();
    check_eq("redir_count", 32'(fq_count), 32'd0);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    check_eq("redir_addr", 32'(imem_addr), 32'h14);
    redirect_valid = 1'b0;
    step();
    check_eq("tgt_pc0", instr_pc, 32'h14);
    check_eq("tgt_instr0", instr, word_at(32'h14));
    step();
    check_eq("tgt_pc1", instr_pc, 32'h18);

    // Misaligned target, then aligned wrap-around target
    redirect_valid = 1'b1; redirect_pc = 32'h1E;
    step();
    check_eq("mis_set", 32'(misalign_err), 32'd1);
    redirect_valid = 1'b0;
    step();
    check_eq("mis_pc", instr_pc, 32'h1C);
    redirect_valid = 1'b1; redirect_pc = 32'h7C;
    step();
    check_eq("mis_sticky", 32'(misalign_err), 32'd1);
    check_eq("wrap_addr0", 32'(imem_addr), 32'h7C);
    redirect_valid = 1'b0;
    step();
    check_eq("wrap_pc0", instr_pc, 32'h7C);
    check_eq("wrap_instr0", instr, word_at(32'h7C));
    check_eq("wrap_addr1", 32'(imem_addr), 32'h00);
    step();
    check_eq("wrap_pc1", instr_pc, 32'h80);
    check_eq("wrap_instr1", instr, word_at(0));
    check_eq("mis_sticky2", 32'(misalign_err), 32'd1);

    // Gating: two queued entries drain, fetch address holds
    instr_ready = 1'b0;
    step();
    check_eq("gate_count2", 32'(fq_count), 32'd2);
    fetch_en = 1'b0; instr_ready = 1'b1;
    step();
    check_eq("gate_pc", instr_pc, 32'h84);
    check_eq("gate_count1", 32'(fq_count), 32'd1);
    step();
    check_eq("gate_empty", 32'(instr_valid), 32'd0);
    check_eq("gate_instr0", instr, 32'd0);
    check_eq("gate_pc0", instr_pc, 32'd0);
    step();
    check_eq("gate_addr", 32'(imem_addr), 32'h08);

    // Asynchronous reset between edges
    fetch_en = 1'b1; instr_ready = 1'b0;
    step(); step();
    check_eq("pre_rst_count", 32'(fq_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(instr_valid), 32'd0);
    check_eq("arst_count", 32'(fq_count), 32'd0);
    check_eq("arst_addr", 32'(imem_addr), 32'd0);
    check_eq("arst_pc", instr_pc, 32'd0);
    check_eq("arst_mis", 32'(misalign_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_pc", instr_pc, 32'd0);
    check_eq("post_rst_count", 32'(fq_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
